// File: rtl/pwm_generator.sv
// 16-channel PCA9685-style PWM: prescaled 12-bit counter, per-channel ON/OFF windows shadowed at
// period boundaries. Optional macro PWM_INVRT_EN lets MODE2.INVRT invert every pwm_o bit.
module pwm_generator #(
   parameter int NUM_CHANNELS = 16,
   parameter int MIN_PRESCALE = 3
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [0:2047]           register_blob_i,
   output logic [NUM_CHANNELS-1:0] pwm_o,
   output logic                    cycle_start_o,
   output logic [11:0]             counter_o
);

   localparam logic [7:0] MIN_PRE       = 8'(MIN_PRESCALE);
   localparam int         SLEEP_BIT     = 3;        // MODE1 bit 4 (byte MSB sits at the lowest index)
   localparam int         PRESCALE_BASE = 8 * 254;

   function automatic logic chan_level(input logic        full_on,
                                       input logic        full_off,
                                       input logic [11:0] on_v,
                                       input logic [11:0] off_v,
                                       input logic [11:0] cnt);
      logic level;
      if (full_off)          level = 1'b0;
      else if (full_on)      level = 1'b1;
      else if (on_v < off_v) level = (cnt >= on_v) && (cnt < off_v);
      else if (on_v > off_v) level = (cnt >= on_v) || (cnt < off_v);
      else                   level = 1'b0;
      return level;
   endfunction

   logic                          sleep;
   logic                          unused_blob;
   logic [NUM_CHANNELS-1:0][11:0] reg_on, reg_off;
   logic [NUM_CHANNELS-1:0]       reg_full_on, reg_full_off;
   logic [7:0]                    reg_prescale;

   logic [7:0]                    div_q, div_d, prescale_q, prescale_d;
   logic [11:0]                   cnt_q, cnt_d;
   logic                          load_pending_q, load_pending_d;
   logic                          cycle_start_q, cycle_start_d;
   logic [NUM_CHANNELS-1:0][11:0] on_q, on_d, off_q, off_d;
   logic [NUM_CHANNELS-1:0]       full_on_q, full_on_d, full_off_q, full_off_d;
   logic [NUM_CHANNELS-1:0]       pwm_q, pwm_d;
   logic                          tick, wrap;

   assign sleep       = register_blob_i[SLEEP_BIT];
   assign unused_blob = ^register_blob_i;

`ifdef PWM_INVRT_EN
   localparam int INVRT_BIT = 8 + 3;
   logic invrt;
   assign invrt = register_blob_i[INVRT_BIT];
`endif

   always_comb begin
      reg_on       = '0;
      reg_off      = '0;
      reg_full_on  = '0;
      reg_full_off = '0;
      for (int n = 0; n < NUM_CHANNELS; n++) begin
         reg_on[n]       = {register_blob_i[8*(7+4*n)+4 +: 4], register_blob_i[8*(6+4*n) +: 8]};
         reg_full_on[n]  = register_blob_i[8*(7+4*n)+3];
         reg_off[n]      = {register_blob_i[8*(9+4*n)+4 +: 4], register_blob_i[8*(8+4*n) +: 8]};
         reg_full_off[n] = register_blob_i[8*(9+4*n)+3];
      end
      reg_prescale = (register_blob_i[PRESCALE_BASE +: 8] < MIN_PRE) ?
                     MIN_PRE : register_blob_i[PRESCALE_BASE +: 8];
   end

   always_comb begin
      div_d          = div_q;
      cnt_d          = cnt_q;
      prescale_d     = prescale_q;
      on_d           = on_q;
      off_d          = off_q;
      full_on_d      = full_on_q;
      full_off_d     = full_off_q;
      load_pending_d = load_pending_q;
      cycle_start_d  = 1'b0;
      pwm_d          = '0;
      tick           = (div_q == prescale_q);
      wrap           = tick && (cnt_q == 12'hFFF);

      if (sleep) begin
         // Sleep abandons the period; the shadow reloads on the first awake clock.
         div_d          = '0;
         cnt_d          = '0;
         load_pending_d = 1'b1;
      end else begin
         load_pending_d = 1'b0;
         cycle_start_d  = wrap;
         if (tick) begin
            div_d = '0;
            cnt_d = cnt_q + 12'd1;
         end else begin
            div_d = div_q + 8'd1;
         end
         if (wrap || load_pending_q) begin
            prescale_d = reg_prescale;
            on_d       = reg_on;
            off_d      = reg_off;
            full_on_d  = reg_full_on;
            full_off_d = reg_full_off;
         end
         for (int n = 0; n < NUM_CHANNELS; n++) begin
            pwm_d[n] = chan_level(full_on_q[n], full_off_q[n], on_q[n], off_q[n], cnt_q);
         end
      end

`ifdef PWM_INVRT_EN
      if (invrt) pwm_d = ~pwm_d;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         div_q          <= '0;
         cnt_q          <= '0;
         prescale_q     <= MIN_PRE;
         on_q           <= '0;
         off_q          <= '0;
         full_on_q      <= '0;
         full_off_q     <= '1;
         load_pending_q <= 1'b1;
         cycle_start_q  <= 1'b0;
         pwm_q          <= '0;
      end else begin
         div_q          <= div_d;
         cnt_q          <= cnt_d;
         prescale_q     <= prescale_d;
         on_q           <= on_d;
         off_q          <= off_d;
         full_on_q      <= full_on_d;
         full_off_q     <= full_off_d;
         load_pending_q <= load_pending_d;
         cycle_start_q  <= cycle_start_d;
         pwm_q          <= pwm_d;
      end
   end

   assign pwm_o         = pwm_q;
   assign cycle_start_o = cycle_start_q;
   assign counter_o     = cnt_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: elapsed-time reference model compared every clock, plus
// hand-computed duty/period/sleep expectations. Honours PWM_INVRT_EN when defined.
`timescale 1ns/1ps
module tb_pwm_generator;

   localparam int NCH     = 16;
   localparam int MIN_PRE = 3;

   // clock / reset
   logic           clk = 1'b0;
   logic           rst_n;
   logic [0:2047]  blob;
   logic [NCH-1:0] pwm;
   logic           cs;
   logic [11:0]    cnt;

   always #5 clk = ~clk;

   pwm_generator #(.NUM_CHANNELS(NCH), .MIN_PRESCALE(MIN_PRE)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .register_blob_i(blob),
      .pwm_o          (pwm),
      .cycle_start_o  (cs),
      .counter_o      (cnt)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] get_byte(input int idx);
      logic [7:0] b;
      b = blob[idx*8 +: 8];
      return b;
   endfunction

   task automatic set_byte(input int idx, input logic [7:0] v);
      blob[idx*8 +: 8] = v;
   endtask

   task automatic set_chan(input int ch, input logic [7:0] on_l, input logic [7:0] on_h,
                           input logic [7:0] off_l, input logic [7:0] off_h);
      set_byte(6 + 4*ch, on_l);
      set_byte(7 + 4*ch, on_h);
      set_byte(8 + 4*ch, off_l);
      set_byte(9 + 4*ch, off_h);
   endtask

   // Reference model: time elapsed in the current period, counter = elapsed / (prescale+1).
   int             m_el;
   bit             m_pend;
   int             m_pre;
   int             m_on  [NCH];
   int             m_off [NCH];
   bit             m_fon [NCH];
   bit             m_foff[NCH];
   bit             m_valid = 1'b0;
   logic [NCH-1:0] exp_pwm;
   logic           exp_cs;
   logic [11:0]    exp_cnt;
   logic [7:0]     md_mode1;
   int             md_cur;

   function automatic bit model_level(input int n, input int c);
      int win, pos;
      if (m_foff[n]) return 1'b0;
      if (m_fon[n])  return 1'b1;
      win = (m_off[n] - m_on[n] + 4096) % 4096;
      pos = (c - m_on[n] + 4096) % 4096;
      return pos < win;
   endfunction

   task automatic model_load();
      logic [7:0] h;
      int raw;
      for (int n = 0; n < NCH; n++) begin
         h          = get_byte(7 + 4*n);
         m_on[n]    = int'(h[3:0]) * 256 + int'(get_byte(6 + 4*n));
         m_fon[n]   = h[4];
         h          = get_byte(9 + 4*n);
         m_off[n]   = int'(h[3:0]) * 256 + int'(get_byte(8 + 4*n));
         m_foff[n]  = h[4];
      end
      raw   = int'(get_byte(254));
      m_pre = (raw < MIN_PRE) ? MIN_PRE : raw;
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         m_el    = 0;
         m_pend  = 1'b1;
         m_pre   = MIN_PRE;
         for (int n = 0; n < NCH; n++) begin
            m_on[n] = 0; m_off[n] = 0; m_fon[n] = 1'b0; m_foff[n] = 1'b1;
         end
         exp_pwm = '0;
         exp_cs  = 1'b0;
         exp_cnt = '0;
         m_valid = 1'b1;
      end else begin
         md_mode1 = get_byte(0);
         md_cur   = m_el / (m_pre + 1);
         exp_cs   = 1'b0;
         if (md_mode1[4]) begin
            exp_pwm = '0;
            m_el    = 0;
            m_pend  = 1'b1;
         end else begin
            for (int n = 0; n < NCH; n++) exp_pwm[n] = model_level(n, md_cur);
            m_el++;
            if (m_el == 4096 * (m_pre + 1)) begin
               m_el   = 0;
               exp_cs = 1'b1;
               model_load();
            end else if (m_pend) begin
               model_load();
            end
            m_pend = 1'b0;
         end
`ifdef PWM_INVRT_EN
         if (blob[11]) exp_pwm = ~exp_pwm;
`endif
         exp_cnt = 12'(m_el / (m_pre + 1));
      end
   end

   // compare process: every clock, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         check("pwm_o", 32'(pwm), 32'(exp_pwm));
         check("counter_o", 32'(cnt), 32'(exp_cnt));
         check("cycle_start_o", 32'(cs), 32'(exp_cs));
      end
   end

   // per-period window statistics (window = cycle_start pulse up to the next one)
   int w_len;
   int w_hi[4];
   int q_len[$];
   int q_hi0[$];
   int q_hi1[$];
   int q_hi2[$];
   int q_hi3[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         w_len = 0;
         for (int i = 0; i < 4; i++) w_hi[i] = 0;
      end else begin
         if (cs === 1'b1) begin
            q_len.push_back(w_len);
            q_hi0.push_back(w_hi[0]);
            q_hi1.push_back(w_hi[1]);
            q_hi2.push_back(w_hi[2]);
            q_hi3.push_back(w_hi[3]);
            w_len = 0;
            for (int i = 0; i < 4; i++) w_hi[i] = 0;
         end
         w_len++;
         for (int i = 0; i < 4; i++) if (pwm[i] === 1'b1) w_hi[i]++;
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_cs(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         step();
         if (cs === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_cnt(input string name, input logic [11:0] target);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         step();
         if (cnt === target) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic sleep_pulse();
      set_byte(0, 8'h10);
      step();
      set_byte(0, 8'h00);
   endtask

   logic [15:0] exp_sleep_inv;

   initial begin
      rst_n = 1'b0;
      blob  = '0;

      // reset with an all-zero image
      repeat (4) step();
      check("reset_pwm", 32'(pwm), 32'd0);
      check("reset_counter", 32'(cnt), 32'd0);
      check("reset_cycle_start", 32'(cs), 32'd0);
      rst_n = 1'b1;
      repeat (3) step();
      check("cnt_after_3clk", 32'(cnt), 32'd0);
      step();
      check("cnt_after_4clk", 32'(cnt), 32'd1);
      repeat (4) step();
      check("cnt_after_8clk", 32'(cnt), 32'd2);
      repeat (40) step();
      check("zero_image_pwm", 32'(pwm), 32'd0);

      // channel patterns, loaded at reset release
      rst_n = 1'b0;
      blob  = '0;
      set_chan(0, 8'h00, 8'h00, 8'h00, 8'h08);
      set_chan(1, 8'h00, 8'h0F, 8'h00, 8'h01);
      set_chan(2, 8'h00, 8'h10, 8'h00, 8'h00);
      set_chan(3, 8'h00, 8'h10, 8'h00, 8'h10);
      for (int ch = 4; ch < NCH; ch++)
         set_chan(ch, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 31)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 31)));
      set_byte(254, 8'h03);
      repeat (2) step();
      rst_n = 1'b1;
      q_len.delete(); q_hi0.delete(); q_hi1.delete(); q_hi2.delete(); q_hi3.delete();
      wait_cs("wait_period1_end");
      wait_cnt("wait_cnt_0x100", 12'h100);
      set_byte(9, 8'h04);
      repeat (3) set_byte(6 + 4*$urandom_range(4, 15) + $urandom_range(0, 3),
                          8'($urandom_range(0, 255)));
      wait_cs("wait_period2_end");
      wait_cs("wait_period3_end");
      step();
      check("window_count", 32'(q_len.size()), 32'd3);
      check("period2_len", 32'(q_len[1]), 32'd16384);
      check("period2_led0_high", 32'(q_hi0[1]), 32'd8192);
      check("period2_led1_high", 32'(q_hi1[1]), 32'd2048);
      check("period2_led2_full_on", 32'(q_hi2[1]), 32'd16384);
      check("period2_led3_full_off", 32'(q_hi3[1]), 32'd0);
      check("period3_len", 32'(q_len[2]), 32'd16384);
      check("period3_led0_high", 32'(q_hi0[2]), 32'd4096);
      check("period3_led1_high", 32'(q_hi1[2]), 32'd2048);

      // sleep mid-period, then inversion while asleep
      repeat (600) step();
      set_byte(0, 8'h10);
      step();
      check("sleep_counter", 32'(cnt), 32'd0);
      check("sleep_pwm", 32'(pwm), 32'd0);
      repeat (10) step();
      check("sleep_cs", 32'(cs), 32'd0);
      check("sleep_counter_held", 32'(cnt), 32'd0);
      set_byte(1, 8'h10);
      step();
`ifdef PWM_INVRT_EN
      exp_sleep_inv = 16'hFFFF;
`else
      exp_sleep_inv = 16'h0000;
`endif
      check("sleep_invrt_pwm", 32'(pwm), 32'(exp_sleep_inv));
      set_byte(1, 8'h00);
      step();
      set_byte(0, 8'h00);
      step();
      check("wake_counter", 32'(cnt), 32'd0);
      repeat (3) step();
      check("wake_counter_first_tick", 32'(cnt), 32'd1);

      // prescale changes apply only at load points
      set_byte(254, 8'h05);
      repeat (20) step();
      sleep_pulse();
      repeat (5) step();
      check("pre5_cnt_after_5", 32'(cnt), 32'd0);
      step();
      check("pre5_cnt_after_6", 32'(cnt), 32'd1);
      set_byte(254, 8'h00);
      sleep_pulse();
      repeat (4) step();
      check("pre0_clamped_cnt", 32'(cnt), 32'd1);

      // randomized register traffic, sleeps, inversion and resets
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = $urandom_range(0, 999);
         if (r < 60)       set_byte(6 + $urandom_range(0, 63), 8'($urandom_range(0, 255)));
         else if (r < 64)  set_byte(0, ($urandom_range(0, 1) == 1) ? 8'h10 : 8'h00);
         else if (r < 66)  set_byte(1, ($urandom_range(0, 1) == 1) ? 8'h10 : 8'h00);
         else if (r < 67)  set_byte(254, 8'($urandom_range(0, 6)));
         else if (r < 68)  rst_n = 1'b0;
         else              rst_n = 1'b1;
         step();
      end
      rst_n = 1'b1;
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Consumes the flat register image from the register file and produces the 16 PCA9685-style PWM channel outputs. Contains the prescaled 12-bit PWM counter and per-channel ON/OFF comparators. Channel settings are shadow-latched at each period boundary, so register writes in mid-period never produce glitches or runt pulses.

## Interface
Parameters:
- NUM_CHANNELS, 16, number of LED channels. Channel n uses registers 0x06+4n..0x09+4n.
- MIN_PRESCALE, 3, lower clamp applied to the PRE_SCALE register (0xFE).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; one clock, reset is synchronous and active-low.
- register_blob_i  in  [0:2047]  register image. Byte n is bits n*8 (MSB) to n*8+7 (LSB).
- pwm_o  out  NUM_CHANNELS  channel outputs, registered.
- cycle_start_o  out  1  one-clock pulse when the PWM counter wraps 4095->0.
- counter_o  out  12  current PWM counter, for debug and verification.

## Operation
- Register decode:
  - MODE1 = byte 0x00; SLEEP = bit 4.
  - MODE2 = byte 0x01; INVRT = bit 4.
  - Channel n:
    - ON = {ON_H[3:0], ON_L}; full_on = ON_H[4].
    - OFF = {OFF_H[3:0], OFF_L}; full_off = OFF_H[4].
  - PRE_SCALE = byte 0xFE. The effective prescale is max(PRE_SCALE, MIN_PRESCALE).
- Divider: div counts 0..prescale. A tick occurs when div == prescale; div then returns to 0.
- Counter:
  - 12-bit; increments on each tick and wraps 4095->0.
  - Period = 4096*(prescale+1) clocks.
- Shadow latch: all channel ON/OFF/full bits and the prescale are copied from register_blob_i at a "load point". Load points are:
  - the wrap tick;
  - the first clock after reset deasserts;
  - the first clock after SLEEP clears.
- Channel output, using shadowed values and cnt = the counter value in the current clock:
  - full_off = 1 -> 0. full_off has priority over full_on.
  - full_on = 1 -> 1.
  - ON < OFF -> 1 when ON <= cnt < OFF.
  - ON > OFF -> 1 when cnt >= ON or cnt < OFF (wrap-around window).
  - ON == OFF -> 0.
- Sleep: SLEEP is read live, not shadowed. While SLEEP = 1:
  - div and counter are held at 0;
  - all channel outputs are 0 before any inversion;
  - cycle_start_o stays 0.
- Inversion: see Configuration. Inversion is applied after the sleep forcing, so sleeping outputs under inversion read 1.

## Timing
- Reset values:
  - pwm_o = 0 and cycle_start_o = 0;
  - counter_o = 0 and div = 0;
  - shadow full_off = 1 on all channels, all other shadow bits 0, shadow prescale = MIN_PRESCALE.
- Output latency: pwm_o reflects the comparison against counter_o with a 1-clock lag. pwm_o at clock k+1 = f(counter_o at clock k).
- cycle_start_o is asserted in the same clock that counter_o first reads 0 after a wrap.
- New shadow values take effect in the comparisons from the first clock with counter == 0. A mid-period register change has no effect until the next wrap.
- SLEEP set mid-period:
  - at the next clock, counter = 0 and outputs are forced;
  - the partial period is abandoned;
  - no cycle_start_o pulse is generated.
- SLEEP cleared: the load point fires on that clock, and counting restarts from 0 with a full period.
- A prescale change in the register takes effect only at a load point. The period in progress always completes at the old rate.
- Reset mid-period returns the block to its reset values in one clock.

## Configuration
- PWM_INVRT_EN defined: MODE2.INVRT = 1 inverts all pwm_o bits. The inversion sits in the final output register, so latency is unchanged.
- PWM_INVRT_EN undefined: INVRT is ignored, and pwm_o is always active-high.

## Test plan
- Reset, blob all zero:
  - pwm_o = 0 throughout reset;
  - after release, counter_o advances once every 4 clocks (prescale clamped 0 -> 3);
  - all channels stay 0, because the shadowed ON == OFF == 0.
- LED0: ON = 0x000, OFF = 0x800, PRE_SCALE = 0x03:
  - after the first wrap, pwm_o[0] is high for 8192 clocks and low for 8192 clocks per 16384-clock period;
  - cycle_start_o pulses every 16384 clocks.
- LED1: ON = 0xF00, OFF = 0x100 (wrap window) -> pwm_o[1] is high for counter 0xF00..0xFFF and 0x000..0x0FF, i.e. 512 ticks per period.
- LED2 full-bit handling:
  - ON_H = 0x10 -> constant 1;
  - ON_H = 0x10 and OFF_H = 0x10 -> constant 0.
- Mid-period update: with LED0 running at OFF = 0x800, write OFF_H = 0x04 at counter 0x100:
  - the current period keeps its 0x800 edge;
  - the next period falls at 0x400.
- Sleep and inversion:
  - MODE1 = 0x10 -> counter_o holds 0 and all pwm_o = 0 within 1 clock;
  - MODE1 = 0x00 -> counting restarts from 0;
  - with PWM_INVRT_EN defined and MODE2 = 0x10, the same sleep gives pwm_o = 0xFFFF.
